// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART constants and FIFO count type
//
// Purpose: default data width and FIFO pointer width for the UART receive and
//          transmit FIFOs, plus the occupancy count type sized to hold 0..DEPTH.
// Ports:   none (package).
package uart_rx_fifo_pkg;

    localparam int UART_DBIT    = 8;
    localparam int UART_FIFO_AW = 4;

    // One extra bit so a completely full FIFO (DEPTH words) is representable.
    typedef logic [UART_FIFO_AW:0] uart_fifo_cnt_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - simple dual-port register array with registered read
//
// Purpose: word storage for the UART FIFOs. One write port, one synchronous
//          read port. The read register clears on reset; the array does not.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset (read register only)
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write word
//   rd_en    - load the read register from rd_addr
//   rd_addr  - read address
//   rd_data  - registered read word, holds until the next rd_en
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DBIT       = UART_DBIT,
    parameter int ADDR_WIDTH = UART_FIFO_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DBIT-1:0]       wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DBIT-1:0]       rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DBIT-1:0] mem_q [DEPTH];
    logic [DBIT-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read samples the array before this edge's write lands, so a read and a
    // write to the same slot (full FIFO) returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with occupancy flags and sticky overrun
//
// Purpose: captures each received word on the receiver's done strobe into a
//          circular buffer and lets the consumer drain it with registered data.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   wr_en/wr_data- word from the receiver (one-cycle strobe)
//   rd_en        - read request; rd_data/rd_valid follow one cycle later
//   empty, full, almost_full, count - occupancy status from registered count
//   overrun      - sticky: a word was dropped while full
//   overrun_clr  - clears overrun (a same-cycle overflow wins)
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DBIT       = UART_DBIT,
    parameter int ADDR_WIDTH = UART_FIFO_AW,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DBIT-1:0]       wr_data,
    input  logic                  rd_en,
    output logic [DBIT-1:0]       rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overrun_q, overrun_d;

    logic rd_accept;
    logic wr_accept;
    logic overflow;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign almost_full = (count_q >= AF_CNT);

    // A read frees a slot in the same cycle, so a write at full is still taken
    // when paired with a read. No bypass: a read while empty is just ignored.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);
    assign overflow  = wr_en && full && !rd_accept;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_accept;
        overrun_d  = overrun_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end

        // Set has priority over clear so a fresh drop is never lost.
        if (overflow) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DBIT       (DBIT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign count    = count_q;
    assign rd_valid = rd_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures each received word on the receiver's one-cycle done strobe and holds it in a circular buffer. The host or bus side drains it through a read handshake with registered read data. It reports occupancy, full, empty and almost-full, plus a sticky overrun flag for words dropped while the buffer is full.

Parameters:
DBIT, 8, data word width; matches the receiver's data width.
ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH = 16 words.
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  write strobe; driven by the receiver's rx_done (one-cycle pulse).
wr_data  input  DBIT  word to store; driven by rx_dout, valid only while wr_en=1.
rd_en  input  1  read request from the consumer.
rd_data  output  DBIT  registered read data.
rd_valid  output  1  one-cycle pulse; rd_data holds a newly popped word.
empty  output  1  count == 0.
full  output  1  count == DEPTH.
almost_full  output  1  count >= AF_THRESH.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overrun  output  1  sticky flag; a write was dropped because the FIFO was full.
overrun_clr  input  1  clears overrun.

Behaviour:
- One clock. Reset is synchronous and active-high: the rising clk edge with rst=1 resets the block. Reset overrides all other inputs in that cycle.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overrun=0. So empty=1, full=0, almost_full=0.
- Reset mid-operation discards all stored words. Memory contents are not cleared and are not observable.
- Accepted write: wr_en && (!full || rd_accept).
  - mem[wr_ptr] <= wr_data.
  - wr_ptr increments and wraps from DEPTH-1 to 0 by natural ADDR_WIDTH-bit overflow.
- Accepted read: rd_accept = rd_en && !empty.
  - Next cycle: rd_data = word at old rd_ptr and rd_valid=1 (1-cycle latency).
  - rd_ptr increments and wraps the same way as wr_ptr.
- rd_en while empty: ignored. rd_valid stays 0 and rd_data holds its last value.
- rd_data holds its value until the next accepted read. It never returns to 0 except on reset.
- count update, registered:
  - +1 on accepted write only.
  - -1 on accepted read only.
  - Unchanged when both occur or neither occurs.
- Simultaneous write and read:
  - When full: both accepted. The read takes the oldest word and the write fills the freed slot. count stays at DEPTH and overrun is not set.
  - When empty: the write is accepted and the read is ignored (no write-to-read bypass). count goes to 1. The word is readable from the following cycle.
- Overflow: wr_en && full && !rd_accept.
  - Word dropped; pointers and count unchanged.
  - overrun <= 1 on the next edge.
- overrun clearing:
  - overrun_clr=1 clears overrun on the next edge.
  - If a new overflow occurs in the same cycle as overrun_clr, set wins and overrun stays 1.
- Flags:
  - empty, full and almost_full are combinational decodes of registered count (no extra latency).
  - They reflect the updated count on the cycle after a write or read.
- Ordering: strict FIFO. Words are read out in exactly the order they were written.
- No state machine; pointer/counter datapath only.

Decomposition:
- Shared package (the existing UART package) adds:
  - default constants UART_DBIT=8, UART_FIFO_AW=4;
  - a typedef for the count type, logic [UART_FIFO_AW:0].
- The TX-side FIFO reuses both.
- One natural sub-module: uart_fifo_mem.
  - Simple dual-port register array: one write port, one synchronous read port.
  - Parameterised by DBIT and ADDR_WIDTH.
  - Pointers, count, flags and overrun stay in uart_rx_fifo.

Test Plan:
- Reset: assert rst for 2 cycles mid-fill (count=5) -> next cycle count=0, empty=1, full=0, overrun=0, rd_valid=0, rd_data=0.
- Ordered fill/drain: write 0x11,0x22,0x33 as single-cycle wr_en pulses, then rd_en three cycles -> rd_valid one cycle after each rd_en; rd_data 0x11,0x22,0x33; empty=1 at end.
- Full and overrun: write 16 words 0x00..0x0F, then write 0xAA -> full=1, count=16, overrun=1 next cycle. Drain all 16: data 0x00..0x0F, 0xAA never appears. Pulse overrun_clr -> overrun=0.
- Simultaneous at full: at count=16, wr_en (0x55) with rd_en -> count stays 16, overrun=0, read returns oldest word, and 0x55 is read last after draining.
- Simultaneous at empty and empty read: rd_en alone while empty -> rd_valid=0. wr_en(0x77) with rd_en while empty -> count=1, rd_valid=0. rd_en next cycle -> rd_data=0x77.
- Wrap-around and thresholds: 40 interleaved writes and reads so both pointers wrap twice -> data order preserved. almost_full toggles exactly at count 11->12 and 12->11. Overflow concurrent with overrun_clr -> overrun remains 1.
